// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the register-file write sequencer and its
// array-side checker.
package mem_seq_pkg;

  localparam int unsigned MEM_DEPTH = 7;
  localparam int unsigned MEM_WIDTH = 8;
  localparam int unsigned MEM_AW    = 3;
  localparam int unsigned MEM_BW    = 3;

  localparam logic [MEM_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  function automatic logic [MEM_WIDTH-1:0] range_mask(
    input logic [MEM_BW-1:0] msb,
    input logic [MEM_BW-1:0] lsb
  );
    logic [MEM_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MEM_WIDTH; i++) begin
      m[i] = (MEM_BW'(i) >= lsb) && (MEM_BW'(i) <= msb);
    end
    return m;
  endfunction

  function automatic logic req_legal(
    input logic [MEM_AW-1:0] addr,
    input logic [MEM_BW-1:0] msb,
    input logic [MEM_BW-1:0] lsb
  );
    return ({1'b0, addr} < (MEM_AW+1)'(MEM_DEPTH)) &&
           ({1'b0, msb} < (MEM_BW+1)'(MEM_WIDTH)) &&
           (lsb <= msb);
  endfunction

endpackage

// File: rtl/mem_wr_sequencer_range_mask_gen.sv
// Combinational part-select mask: bits lsb..msb set, empty when lsb > msb.
module range_mask_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BW    = 3
) (
  input  logic [BW-1:0]    msb,
  input  logic [BW-1:0]    lsb,
  output logic [WIDTH-1:0] mask
);

  // Per-bit compare avoids the 1 << (msb+1) overflow on a full-word select.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      mask[i] = (BW'(i) >= lsb) && (BW'(i) <= msb);
    end
  end

endmodule

// File: rtl/mem_wr_sequencer.sv
// Write-port sequencer: zero-fills the register-file array after reset or a
// clear request, then turns client part-select writes into masked writes.
module mem_wr_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned BW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [BW-1:0]    req_msb,
  input  logic [BW-1:0]    req_lsb,
  input  logic [WIDTH-1:0] req_data,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wmask,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             init_done,
  output logic             busy,
  output logic             err
);

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              we_d, init_d, err_d;
  logic [AW-1:0]     addr_d;
  logic [WIDTH-1:0]  mask_d, wdata_d;
  logic [WIDTH-1:0]  req_mask;
  logic              legal;
  logic              accept;

  range_mask_gen #(.WIDTH(WIDTH), .BW(BW)) u_mask (
    .msb  (req_msb),
    .lsb  (req_lsb),
    .mask (req_mask)
  );

  assign legal = ({1'b0, req_addr} < (AW+1)'(DEPTH)) &&
                 ({1'b0, req_msb} < (BW+1)'(WIDTH)) &&
                 (req_lsb <= req_msb);

  assign req_ready = (state_q == RUN) && !clr_req;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = mem_addr;
    mask_d  = mem_wmask;
    wdata_d = mem_wdata;
    init_d  = init_done;
    case (state_q)
      CLEAR: begin
        if (clr_req) begin
          cnt_d = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          mask_d  = '1;
          wdata_d = '0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
            init_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          init_d  = 1'b0;
        end else if (accept) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = req_addr;
            mask_d  = req_mask;
            wdata_d = (req_data << req_lsb) & req_mask;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wmask <= mask_d;
      mem_wdata <= wdata_d;
      init_done <= init_d;
      err       <= err_d;
    end
  end

endmodule
